// File: rtl/adc_capture_buffer.sv
// Triggered burst capture of dual-channel ADC sample pairs into block RAM, played out on a valid/ready stream.
// Optional pre-trigger history (circular RAM while armed, extra pre_len input): define ADC_CAPTURE_PRETRIG_EN.
module adc_capture_buffer #(
  parameter int DW = 14,
  parameter int AW = 10
) (
  input  logic            sclk,
  input  logic            rst,
  input  logic            adc_valid,
  input  logic [DW-1:0]   adc_da,
  input  logic [DW-1:0]   adc_db,
  input  logic            arm,
  input  logic            abort,
  input  logic            force_trig,
  input  logic            trig_src,
  input  logic [DW-1:0]   trig_level,
  input  logic [AW:0]     cap_len,
`ifdef ADC_CAPTURE_PRETRIG_EN
  input  logic [AW-1:0]   pre_len,
`endif
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] rd_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic            rd_last,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  state_t          state_q;
  logic [AW:0]     len_q;
  logic [AW:0]     wr_cnt_q;
  logic [AW:0]     rd_cnt_q;
  logic [AW:0]     len_clamped;
  logic [AW:0]     first_cnt;
  logic [DW-1:0]   prev_q;
  logic [DW-1:0]   cur;
  logic            prev_ok_q;
  logic            force_q;
  logic [AW-1:0]   base_addr;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic            trig_ok;
  logic            level_hit;
  logic            trig_fire;
  logic            cap_write;
  logic            cap_last;
  logic            we;
  logic            ren;
  logic            out_adv;
  logic            fin;
  logic            s1_v_q;
  logic            s1_last_q;
  logic [2*DW-1:0] ram_q;
  logic [2*DW-1:0] mem [0:(1<<AW)-1];

  always_comb begin
    len_clamped = cap_len;
    if (cap_len == '0 || cap_len > DEPTH) len_clamped = DEPTH;
  end

  // Unsigned compare on raw offset-binary codes; a crossing needs a previous sample below the level.
  assign cur       = trig_src ? adc_db : adc_da;
  assign level_hit = prev_ok_q && (prev_q < trig_level) && (cur >= trig_level);
  assign trig_fire = (state_q == S_ARMED) && adc_valid && trig_ok && (force_q || level_hit);
  assign cap_write = (state_q == S_CAPTURE) && adc_valid;
  assign cap_last  = cap_write && (wr_cnt_q == len_q - ONE);

`ifdef ADC_CAPTURE_PRETRIG_EN
  localparam logic [AW-1:0] ONE_A = AW'(1);

  logic [AW-1:0] pre_q;
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] stored_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] pre_clamped;
  logic [AW:0]   len_m1;

  assign len_m1      = len_clamped - ONE;
  assign pre_clamped = ({1'b0, pre_len} > len_m1) ? len_m1[AW-1:0] : pre_len;
  assign trig_ok     = (stored_q >= pre_q);
  assign first_cnt   = {1'b0, pre_q} + ONE;
  assign base_addr   = base_q;
  assign we          = adc_valid && (state_q == S_ARMED || state_q == S_CAPTURE);
  assign wr_addr     = (state_q == S_ARMED) ? wptr_q : base_q + wr_cnt_q[AW-1:0];

  // History ring: every armed sample lands at wptr; burst origin sits pre_q entries behind the trigger.
  always_ff @(posedge sclk) begin
    if (rst || abort) begin
      pre_q    <= '0;
      wptr_q   <= '0;
      stored_q <= '0;
      base_q   <= '0;
    end else if (state_q == S_IDLE) begin
      if (arm) begin
        pre_q    <= pre_clamped;
        wptr_q   <= '0;
        stored_q <= '0;
      end
    end else if (state_q == S_ARMED && adc_valid) begin
      wptr_q <= wptr_q + ONE_A;
      if (stored_q < pre_q) stored_q <= stored_q + ONE_A;
      if (trig_fire) base_q <= wptr_q - pre_q;
    end
  end
`else
  assign trig_ok   = 1'b1;
  assign first_cnt = ONE;
  assign base_addr = '0;
  assign we        = trig_fire || cap_write;
  assign wr_addr   = (state_q == S_ARMED) ? '0 : wr_cnt_q[AW-1:0];
`endif

  assign rd_addr = base_addr + rd_cnt_q[AW-1:0];

  always_ff @(posedge sclk) begin
    if (we) mem[wr_addr] <= {adc_da, adc_db};
    if (ren) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge sclk) begin
    if (rst || abort) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      wr_cnt_q  <= '0;
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      force_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          force_q <= 1'b0;
          if (arm) begin
            state_q   <= S_ARMED;
            len_q     <= len_clamped;
            prev_ok_q <= 1'b0;
          end
        end
        S_ARMED: begin
          if (adc_valid) begin
            prev_q    <= cur;
            prev_ok_q <= 1'b1;
          end
          if (trig_fire) begin
            force_q  <= 1'b0;
            wr_cnt_q <= first_cnt;
            state_q  <= (first_cnt == len_q) ? S_READOUT : S_CAPTURE;
          end else if (force_trig) begin
            force_q <= 1'b1;
          end
        end
        S_CAPTURE: begin
          force_q <= 1'b0;
          if (cap_write) begin
            wr_cnt_q <= wr_cnt_q + ONE;
            if (cap_last) state_q <= S_READOUT;
          end
        end
        default: begin
          force_q <= 1'b0;
          if (fin) state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stream: a pair moves when rd_valid & rd_ready at a rising edge; while rd_valid & !rd_ready,
  // rd_data/rd_valid/rd_last hold. s1 is the RAM read stage; it refills whenever the output moves.
  assign out_adv = !rd_valid || rd_ready;
  assign ren     = (state_q == S_READOUT) && (rd_cnt_q != len_q) && (!s1_v_q || out_adv);
  assign fin     = rd_valid && rd_ready && rd_last;

  always_ff @(posedge sclk) begin
    if (rst || abort || state_q != S_READOUT || fin) begin
      rd_cnt_q  <= '0;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (ren) begin
        rd_cnt_q  <= rd_cnt_q + ONE;
        s1_last_q <= (rd_cnt_q == len_q - ONE);
        s1_v_q    <= 1'b1;
      end else if (out_adv) begin
        s1_v_q <= 1'b0;
      end
      if (out_adv) begin
        rd_valid <= s1_v_q;
        if (s1_v_q) begin
          rd_data <= ram_q;
          rd_last <= s1_last_q;
        end
      end
    end
  end

  assign busy  = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done  = (state_q == S_READOUT);
  assign state = state_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Bench for adc_capture_buffer (AW = 4): per-session burst model from the sample list, stream scoreboard.
module tb_adc_capture_buffer;
  localparam int DW = 14;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic            sclk, rst, adc_valid, arm, abort, force_trig, trig_src, rd_ready;
  logic [DW-1:0]   adc_da, adc_db, trig_level;
  logic [AW:0]     cap_len;
  logic            busy, done, rd_valid, rd_last;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      state;
`ifdef ADC_CAPTURE_PRETRIG_EN
  logic [AW-1:0]   pre_len;
`endif

  int              n_checks, n_pass;
  logic [2*DW-1:0] exp_q[$];
  logic            exp_last_q[$];
  logic [2*DW-1:0] rcv_q[$];
  int              ready_mode;
  bit              done_ever;

  adc_capture_buffer #(.DW(DW), .AW(AW)) dut (
    .sclk(sclk), .rst(rst), .adc_valid(adc_valid), .adc_da(adc_da), .adc_db(adc_db),
    .arm(arm), .abort(abort), .force_trig(force_trig), .trig_src(trig_src),
    .trig_level(trig_level), .cap_len(cap_len),
`ifdef ADC_CAPTURE_PRETRIG_EN
    .pre_len(pre_len),
`endif
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .state(state)
  );

  // clock / reset
  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // behavioural model
  function automatic int model_len(input logic [AW:0] cap);
    if (cap == 0 || int'(cap) > DEPTH) return DEPTH;
    return int'(cap);
  endfunction

  function automatic int find_trig(input logic [DW-1:0] w[$], input int lvl, input int f_idx);
    for (int i = 0; i < w.size(); i++) begin
      if (i >= f_idx) return i;
      if (i > 0 && int'(w[i-1]) < lvl && int'(w[i]) >= lvl) return i;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] got_a(input int i);
    if (i < rcv_q.size()) return rcv_q[i][2*DW-1:DW];
    return '1;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic drive_sample(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gmax);
    adc_da = a;
    adc_db = b;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    repeat ($urandom_range(0, gmax)) tick();
  endtask

  task automatic do_arm(input bit src, input logic [DW-1:0] lvl, input logic [AW:0] cap);
    trig_src = src;
    trig_level = lvl;
    cap_len = cap;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    @(negedge sclk);
    check("armed_state", 64'(state), 64'd1);
    check("armed_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && state == 2'd0) && k < 600) begin
      @(negedge sclk);
      k++;
    end
    check(name, 64'(exp_q.size() == 0 && state == 2'd0), 64'd1);
  endtask

  task automatic run_session(input logic [DW-1:0] sa[$], input logic [DW-1:0] sb[$], input bit src,
                             input logic [DW-1:0] lvl, input logic [AW:0] cap, input int f_idx,
                             input int idle_pre, output int t);
    logic [DW-1:0] w[$];
    int len;
    len = model_len(cap);
    w = {};
    for (int i = 0; i < sa.size(); i++) w.push_back(src ? sb[i] : sa[i]);
    t = find_trig(w, int'(lvl), f_idx);
    check("session_cfg", 64'(t >= 0 && t + len <= sa.size()), 64'd1);
    exp_q.delete();
    exp_last_q.delete();
    rcv_q.delete();
    if (t >= 0) begin
      for (int k = 0; k < len && t + k < sa.size(); k++) begin
        exp_q.push_back({sa[t+k], sb[t+k]});
        exp_last_q.push_back(k == len - 1);
      end
    end
    repeat (idle_pre) drive_sample('0, '0, 0);
    do_arm(src, lvl, cap);
    for (int i = 0; i < sa.size(); i++) begin
      if (i == f_idx) begin
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
      end
      drive_sample(sa[i], sb[i], 2);
    end
    wait_done("burst_drained");
  endtask

  // ready generator
  initial begin
    logic [3:0] pat;
    int pat_i;
    pat = 4'b1001;
    pat_i = 0;
    rd_ready = 1'b0;
    forever begin
      @(posedge sclk);
      #1;
      case (ready_mode)
        0: rd_ready = ($urandom_range(0, 9) < 7);
        1: begin
          rd_ready = pat[pat_i % 4];
          pat_i++;
        end
        default: rd_ready = 1'b1;
      endcase
    end
  end

  // scoreboard / compare process
  initial begin
    logic [2*DW-1:0] pd, e;
    logic pl, el;
    bit stalled, pend_idle, lat_pend;
    logic pdone;
    int cyc, done_cyc;
    stalled = 0; pend_idle = 0; lat_pend = 0; pdone = 0; cyc = 0; done_cyc = 0;
    pd = '0; pl = 0;
    forever begin
      @(negedge sclk);
      cyc++;
      if (!rst) begin
        if (pend_idle) begin
          check("idle_after_last", 64'({state, done, rd_valid}), 64'd0);
          pend_idle = 0;
        end
        if (stalled) begin
          check("stall_valid", 64'(rd_valid), 64'd1);
          check("stall_data", 64'(rd_data), 64'(pd));
          check("stall_last", 64'(rd_last), 64'(pl));
        end
        if (done) done_ever = 1;
        if (done && !pdone) begin
          done_cyc = cyc;
          lat_pend = 1;
        end
        if (lat_pend && rd_valid) begin
          check("valid_latency", 64'(cyc - done_cyc), 64'd2);
          lat_pend = 0;
        end
        if (rd_valid && rd_ready) begin
          rcv_q.push_back(rd_data);
          if (exp_q.size() == 0) begin
            check("unexpected_pair", 64'(rd_data), 64'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            el = exp_last_q.pop_front();
            check("rd_data", 64'(rd_data), 64'(e));
            check("rd_last", 64'(rd_last), 64'(el));
          end
          if (rd_last) pend_idle = 1;
        end
        stalled = rd_valid && !rd_ready;
        pd = rd_data;
        pl = rd_last;
      end
      pdone = done;
    end
  end

  // test sequence
  initial begin
    logic [DW-1:0] sa[$], sb[$];
    int t, n, f, len;
    logic [AW:0] cap;
    n_checks = 0; n_pass = 0; ready_mode = 0; done_ever = 0;
    rst = 1'b1; adc_valid = 0; arm = 0; abort = 0; force_trig = 0; trig_src = 0;
    adc_da = '0; adc_db = '0; trig_level = '0; cap_len = '0;
`ifdef ADC_CAPTURE_PRETRIG_EN
    pre_len = '0;
`endif
    repeat (3) tick();
    @(negedge sclk);
    check("rst_state", 64'(state), 64'd0);
    check("rst_flags", 64'({busy, done, rd_valid, rd_last}), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);
    rst = 1'b0;
    tick();

    // ramp on A, crossing at 500
    sa = {}; sb = {};
    for (int i = 0; i <= 10; i++) begin
      sa.push_back(DW'(i * 100));
      sb.push_back(DW'(i * 3 + 7));
    end
    run_session(sa, sb, 1'b0, 14'd500, 5'd4, 99, 0, t);
    check("model_trig_ramp", 64'(t), 64'd5);
    check("ramp_first_a", 64'(got_a(0)), 64'd500);
    check("ramp_last_a", 64'(got_a(3)), 64'd800);

    // first armed sample above level must not trigger; 400 -> 550 does
    sa = {14'd600, 14'd400, 14'd550, 14'd560, 14'd570, 14'd580};
    sb = {};
    for (int i = 0; i < 6; i++) sb.push_back(DW'($urandom_range(0, 16383)));
    run_session(sa, sb, 1'b0, 14'd500, 5'd3, 99, 1, t);
    check("model_trig_noprev", 64'(t), 64'd2);
    check("noprev_first_a", 64'(got_a(0)), 64'd550);

    // force trigger on a flat channel A
    sa = {}; sb = {};
    for (int i = 0; i < 8; i++) begin
      sa.push_back(14'd10);
      sb.push_back(DW'($urandom_range(0, 16383)));
    end
    run_session(sa, sb, 1'b0, 14'd500, 5'd2, 3, 0, t);
    check("force_a0", 64'(got_a(0)), 64'd10);
    check("force_a1", 64'(got_a(1)), 64'd10);
    check("force_b0", 64'(rcv_q.size() > 0 ? rcv_q[0][DW-1:0] : 14'h3FFF), 64'(sb[3]));

    // stalled readout, ready pattern 1,0,0,1
    ready_mode = 1;
    sa = {}; sb = {};
    for (int i = 0; i < 16; i++) begin
      sa.push_back(DW'(i * 50));
      sb.push_back(DW'($urandom_range(0, 16383)));
    end
    run_session(sa, sb, 1'b0, 14'd300, 5'd8, 99, 0, t);
    check("stall_count", 64'(rcv_q.size()), 64'd8);

    // abort after 3 of 16 pairs
    ready_mode = 2;
    rcv_q.delete(); exp_q.delete(); exp_last_q.delete();
    done_ever = 0;
    do_arm(1'b0, 14'd500, 5'd16);
    drive_sample(14'd0, 14'd1, 0);
    drive_sample(14'd600, 14'd2, 0);
    drive_sample(14'd700, 14'd3, 0);
    drive_sample(14'd800, 14'd4, 0);
    @(negedge sclk);
    check("abort_pre_state", 64'(state), 64'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge sclk);
    check("abort_state", 64'(state), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 16; i++) drive_sample(DW'(900 + i), 14'd0, 1);
    repeat (20) tick();
    check("abort_no_done", 64'(done_ever), 64'd0);
    check("abort_no_data", 64'(rcv_q.size()), 64'd0);

    // re-arm after abort, then full-depth bursts via cap_len 0 and an oversize cap_len
    ready_mode = 0;
    sa = {}; sb = {};
    for (int i = 0; i < 24; i++) begin
      sa.push_back(DW'($urandom_range(0, 16383)));
      sb.push_back(DW'(i * 40));
    end
    run_session(sa, sb, 1'b1, 14'd200, 5'd0, 99, 0, t);
    check("model_trig_full", 64'(t), 64'd5);
    check("full_count", 64'(rcv_q.size()), 64'd16);
    run_session(sa, sb, 1'b1, 14'd200, 5'd20, 99, 0, t);
    check("over_count", 64'(rcv_q.size()), 64'd16);

    // single-pair burst
    run_session(sa, sb, 1'b1, 14'd200, 5'd1, 99, 0, t);
    check("one_count", 64'(rcv_q.size()), 64'd1);

    // randomized sessions
    for (int s = 0; s < 30; s++) begin
      cap = AW'(0) + 5'($urandom_range(0, 20));
      len = model_len(cap);
      f = $urandom_range(0, 10);
      n = f + len + 2;
      sa = {}; sb = {};
      for (int i = 0; i < n; i++) begin
        sa.push_back(DW'($urandom_range(0, 2000)));
        sb.push_back(DW'($urandom_range(0, 2000)));
      end
      ready_mode = $urandom_range(0, 2);
      run_session(sa, sb, 1'($urandom_range(0, 1)), DW'($urandom_range(0, 2000)), cap, f,
                  $urandom_range(0, 2), t);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_capture_buffer.md
Name: adc_capture_buffer

Overview:
- Downstream stage of the dual-channel 14-bit ADC deserializer.
- Consumes the parallel A/B sample pairs and watches one channel for a level-crossing trigger.
- After a trigger, stores a fixed-length burst of sample pairs into internal block RAM.
- Plays the burst out over a valid/ready stream to the host-side readout logic. One clock domain (sclk); the upstream clock-domain crossing delivers a one-cycle adc_valid strobe per sample.

Parameters:
- DW, 14: sample width per channel.
- AW, 10: RAM address width; buffer depth is 2^AW sample pairs.

Ports:
- sclk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- adc_valid  in  1  one-cycle strobe, new sample pair present.
- adc_da  in  DW  channel A sample, offset-binary.
- adc_db  in  DW  channel B sample, offset-binary.
- arm  in  1  pulse: start waiting for trigger (honoured in IDLE only).
- abort  in  1  pulse: return to IDLE from any state.
- force_trig  in  1  pulse: trigger on next valid sample regardless of level.
- trig_src  in  1  0 = watch channel A, 1 = watch channel B.
- trig_level  in  DW  trigger threshold, unsigned compare.
- cap_len  in  AW+1  burst length; latched on accepted arm.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in READOUT.
- rd_data  out  2*DW  {A,B} sample pair.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts when rd_valid and rd_ready are both high.
- rd_last  out  1  marks final pair of burst.
- state  out  2  0 = IDLE, 1 = ARMED, 2 = CAPTURE, 3 = READOUT.

Behaviour:
- Reset (rst high at sclk edge): state IDLE; busy, done, rd_valid, rd_last = 0; rd_data = 0; internal counters and the force flag cleared; RAM contents undefined, not cleared. Reset mid-capture or mid-readout discards the burst.
- cap_len latching: 0 or any value > 2^AW is latched as 2^AW.
- IDLE -> ARMED: on arm. The arm cycle itself does not sample adc_valid.
- ARMED:
  - Keeps prev = watched channel of the last valid sample; prev_ok set after the first valid sample.
  - Trigger = adc_valid & prev_ok & (prev < trig_level) & (cur >= trig_level).
  - force_trig sets a flag; the next valid sample triggers unconditionally.
  - On trigger, the triggering pair is written to address 0 and the block enters CAPTURE with wr_cnt = 1.
- CAPTURE:
  - Each valid pair is written at address wr_cnt; wr_cnt increments.
  - When the write of pair len-1 occurs, go to READOUT on the next edge.
  - If len = 1, go ARMED -> READOUT directly.
- READOUT:
  - done = 1 from the first READOUT cycle.
  - rd_valid rises exactly 2 cycles after done rises (sync RAM read plus output register).
  - Pairs are presented in address order 0..len-1. rd_data, rd_valid and rd_last are held stable while rd_valid & !rd_ready.
  - Back-to-back handshakes sustain 1 pair per cycle (prefetch).
  - rd_last = 1 only with pair len-1. On its handshake: next cycle state IDLE, done = 0, rd_valid = 0.
- adc_valid during READOUT or IDLE: ignored (samples dropped).
- abort: next state IDLE, all outputs to their reset values. abort wins over simultaneous arm, trigger or final handshake.
- arm outside IDLE: ignored. force_trig outside ARMED: ignored, flag cleared.
- Comparison is unsigned on the raw offset-binary code. A level of 0 can never trigger by crossing; use force_trig.

Optional Feature:
- Macro: ADC_CAPTURE_PRETRIG_EN.
- When defined:
  - The RAM runs as a circular buffer during ARMED, continuously writing valid pairs.
  - The extra input pre_len (AW bits) is latched on arm and clamped to len-1.
  - Trigger is honoured only once pre_len pairs are stored.
  - Readout starts at trigger_addr - pre_len modulo 2^AW, so the burst is pre_len pre-trigger pairs, then the trigger pair, then post-trigger pairs; total len pairs.
- When undefined: no pre_len port, no writes in ARMED, behaviour exactly as above.

Test Plan:
- Ramp on A 0,100,...,1000 (trig_src = 0, trig_level = 500, cap_len = 4, arm) -> trigger on sample 500; rd_data A = 500,600,700,800; rd_last on 800; then IDLE.
- ARMED, first valid sample A = 600 with level 500 (no prior sample) -> no trigger; next samples 400 then 550 -> trigger on 550.
- force_trig in ARMED, constant A = 10, cap_len = 2 -> burst {10,10}; B channel data preserved in rd_data[DW-1:0].
- Readout with rd_ready toggling 1,0,0,1 (cap_len = 8) -> rd_data stable while stalled; exactly 8 handshakes; rd_valid 2 cycles after done.
- abort asserted mid-CAPTURE after 3 of 16 pairs -> state 0 next cycle, busy = 0, done never rises; re-arm works.
- cap_len = 0 with AW = 4 -> 16 pairs captured and read, rd_last on the 16th.
